// File: rtl/pio_sm_fifo.sv
// pio_sm_fifo: TX/RX word FIFO pair between the PIO bus registers and one state machine.
//   Parameters: DEPTH words per direction when unjoined; LVLW level width (2^LVLW > 2*DEPTH).
//   clk, reset            : clock, synchronous active-high reset
//   in_joinTX, in_joinRX  : join storage into one 2*DEPTH FIFO (TX wins if both set)
//   in_flush              : empty both FIFOs
//   in_clearFlags         : clear sticky error flags
//   in_busTXWrite/Data    : bus push into TX
//   in_busRXRead          : bus pop from RX; out_busRXData is the RX head
//   in_TXFifoDataAck      : SM pop from TX; out_dataTXFifo is the TX head
//   in_RXFifoDataValid/in_dataRXFifo : SM push into RX
//   out_*Empty/Full/Level : occupancy status
//   out_TXOverflow, out_RXUnderflow, out_TXStall, out_RXStall : sticky rejection flags
module pio_sm_fifo #(
    parameter int DEPTH = 4,
    parameter int LVLW  = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_joinTX,
    input  logic            in_joinRX,
    input  logic            in_flush,
    input  logic            in_clearFlags,
    input  logic            in_busTXWrite,
    input  logic [31:0]     in_busTXData,
    input  logic            in_busRXRead,
    output logic [31:0]     out_busRXData,
    input  logic            in_TXFifoDataAck,
    output logic [31:0]     out_dataTXFifo,
    output logic            out_TXFifoEmpty,
    output logic            out_TXFifoFull,
    input  logic            in_RXFifoDataValid,
    input  logic [31:0]     in_dataRXFifo,
    output logic            out_RXFifoFull,
    output logic            out_RXFifoEmpty,
    output logic [LVLW-1:0] out_TXLevel,
    output logic [LVLW-1:0] out_RXLevel,
    output logic            out_TXOverflow,
    output logic            out_RXUnderflow,
    output logic            out_TXStall,
    output logic            out_RXStall
);
    localparam int AW = $clog2(2 * DEPTH);
    localparam logic [LVLW-1:0] CAP_FULL = LVLW'(2 * DEPTH);
    localparam logic [LVLW-1:0] CAP_HALF = LVLW'(DEPTH);

    logic [31:0]     mem_q [2*DEPTH];
    logic [1:0]      join_q, join_d;
    logic [AW-1:0]   tx_rd_q, tx_rd_d, tx_wr_q, tx_wr_d;
    logic [AW-1:0]   rx_rd_q, rx_rd_d, rx_wr_q, rx_wr_d;
    logic [LVLW-1:0] tx_lvl_q, tx_lvl_d, rx_lvl_q, rx_lvl_d;
    logic [3:0]      flags_q, flags_d;

    logic [LVLW-1:0] tx_cap, rx_cap;
    logic [AW-1:0]   rx_base;
    logic            flush, tx_empty, tx_full, rx_empty, rx_full;
    logic            tx_push_ok, tx_pop_ok, rx_push_ok, rx_pop_ok;
    logic            tx_we, rx_we;
    logic [3:0]      flags_set;

    // Advance a pointer, wrapping at the current capacity of its FIFO.
    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p, input logic [LVLW-1:0] cap);
        return (LVLW'(p) + LVLW'(1) == cap) ? '0 : p + AW'(1);
    endfunction

    always_comb begin
        join_d     = {in_joinTX, in_joinRX};
        flush      = in_flush || (join_d != join_q);
        // Capacity follows the registered join mode; a mode change flushes in the same cycle.
        tx_cap     = join_q[1] ? CAP_FULL : join_q[0] ? '0 : CAP_HALF;
        rx_cap     = join_q[1] ? '0 : join_q[0] ? CAP_FULL : CAP_HALF;
        rx_base    = (join_q == 2'b01) ? '0 : AW'(DEPTH);
        // A zero-capacity FIFO reads as both empty and full, so it rejects everything.
        tx_empty   = tx_lvl_q == '0;
        tx_full    = tx_lvl_q == tx_cap;
        rx_empty   = rx_lvl_q == '0;
        rx_full    = rx_lvl_q == rx_cap;
        tx_pop_ok  = in_TXFifoDataAck && !tx_empty;
        tx_push_ok = in_busTXWrite && (!tx_full || tx_pop_ok);
        rx_pop_ok  = in_busRXRead && !rx_empty;
        rx_push_ok = in_RXFifoDataValid && (!rx_full || rx_pop_ok);
        tx_we      = tx_push_ok && !flush;
        rx_we      = rx_push_ok && !flush;
        tx_rd_d    = flush ? '0 : tx_pop_ok ? nxt(tx_rd_q, tx_cap) : tx_rd_q;
        tx_wr_d    = flush ? '0 : tx_push_ok ? nxt(tx_wr_q, tx_cap) : tx_wr_q;
        rx_rd_d    = flush ? '0 : rx_pop_ok ? nxt(rx_rd_q, rx_cap) : rx_rd_q;
        rx_wr_d    = flush ? '0 : rx_push_ok ? nxt(rx_wr_q, rx_cap) : rx_wr_q;
        tx_lvl_d   = flush ? '0 : tx_lvl_q + LVLW'(tx_push_ok) - LVLW'(tx_pop_ok);
        rx_lvl_d   = flush ? '0 : rx_lvl_q + LVLW'(rx_push_ok) - LVLW'(rx_pop_ok);
        flags_set  = {in_busTXWrite && !tx_push_ok, in_busRXRead && !rx_pop_ok,
                      in_TXFifoDataAck && !tx_pop_ok, in_RXFifoDataValid && !rx_push_ok};
        // Setting beats clearing in the same cycle.
        flags_d    = flags_set | (in_clearFlags ? 4'b0 : flags_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            join_q   <= '0;
            tx_rd_q  <= '0;
            tx_wr_q  <= '0;
            rx_rd_q  <= '0;
            rx_wr_q  <= '0;
            tx_lvl_q <= '0;
            rx_lvl_q <= '0;
            flags_q  <= '0;
        end else begin
            join_q   <= join_d;
            tx_rd_q  <= tx_rd_d;
            tx_wr_q  <= tx_wr_d;
            rx_rd_q  <= rx_rd_d;
            rx_wr_q  <= rx_wr_d;
            tx_lvl_q <= tx_lvl_d;
            rx_lvl_q <= rx_lvl_d;
            flags_q  <= flags_d;
        end
    end

    // Storage is never cleared; emptiness masks stale words on the outputs.
    always_ff @(posedge clk) begin
        if (!reset && tx_we) mem_q[tx_wr_q] <= in_busTXData;
        if (!reset && rx_we) mem_q[rx_base + rx_wr_q] <= in_dataRXFifo;
    end

    assign out_dataTXFifo  = tx_empty ? 32'h0 : mem_q[tx_rd_q];
    assign out_busRXData   = rx_empty ? 32'h0 : mem_q[rx_base + rx_rd_q];
    assign out_TXFifoEmpty = tx_empty;
    assign out_TXFifoFull  = tx_full;
    assign out_RXFifoEmpty = rx_empty;
    assign out_RXFifoFull  = rx_full;
    assign out_TXLevel     = tx_lvl_q;
    assign out_RXLevel     = rx_lvl_q;
    assign {out_TXOverflow, out_RXUnderflow, out_TXStall, out_RXStall} = flags_q;
endmodule

// File: tb/tb_pio_sm_fifo.sv
// tb_pio_sm_fifo: directed scoreboard bench for pio_sm_fifo with DEPTH=4.
module tb_pio_sm_fifo;
    logic        clk = 0;
    logic        reset = 1;
    logic        in_joinTX = 0, in_joinRX = 0, in_flush = 0, in_clearFlags = 0;
    logic        in_busTXWrite = 0, in_busRXRead = 0, in_TXFifoDataAck = 0, in_RXFifoDataValid = 0;
    logic [31:0] in_busTXData = 0, in_dataRXFifo = 0;
    logic [31:0] out_busRXData, out_dataTXFifo;
    logic        out_TXFifoEmpty, out_TXFifoFull, out_RXFifoFull, out_RXFifoEmpty;
    logic [3:0]  out_TXLevel, out_RXLevel;
    logic        out_TXOverflow, out_RXUnderflow, out_TXStall, out_RXStall;
    int          checks = 0, errors = 0;
    logic [31:0] tx_exp[$], rx_exp[$];

    pio_sm_fifo #(.DEPTH(4), .LVLW(4)) dut (
        .clk(clk), .reset(reset), .in_joinTX(in_joinTX), .in_joinRX(in_joinRX),
        .in_flush(in_flush), .in_clearFlags(in_clearFlags),
        .in_busTXWrite(in_busTXWrite), .in_busTXData(in_busTXData),
        .in_busRXRead(in_busRXRead), .out_busRXData(out_busRXData),
        .in_TXFifoDataAck(in_TXFifoDataAck), .out_dataTXFifo(out_dataTXFifo),
        .out_TXFifoEmpty(out_TXFifoEmpty), .out_TXFifoFull(out_TXFifoFull),
        .in_RXFifoDataValid(in_RXFifoDataValid), .in_dataRXFifo(in_dataRXFifo),
        .out_RXFifoFull(out_RXFifoFull), .out_RXFifoEmpty(out_RXFifoEmpty),
        .out_TXLevel(out_TXLevel), .out_RXLevel(out_RXLevel),
        .out_TXOverflow(out_TXOverflow), .out_RXUnderflow(out_RXUnderflow),
        .out_TXStall(out_TXStall), .out_RXStall(out_RXStall)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    // Monitor: whenever a pop is presented, the head must match the scoreboard.
    always @(negedge clk) begin
        if (!reset && in_TXFifoDataAck && !out_TXFifoEmpty) begin
            checks++;
            if (tx_exp.size() == 0) begin
                errors++;
                $display("FAIL tx_pop unexpected got %h", out_dataTXFifo);
            end else begin
                automatic logic [31:0] e = tx_exp.pop_front();
                if (out_dataTXFifo !== e) begin
                    errors++;
                    $display("FAIL tx_pop got %h exp %h", out_dataTXFifo, e);
                end
            end
        end
        if (!reset && in_busRXRead && !out_RXFifoEmpty) begin
            checks++;
            if (rx_exp.size() == 0) begin
                errors++;
                $display("FAIL rx_pop unexpected got %h", out_busRXData);
            end else begin
                automatic logic [31:0] e = rx_exp.pop_front();
                if (out_busRXData !== e) begin
                    errors++;
                    $display("FAIL rx_pop got %h exp %h", out_busRXData, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        in_busTXWrite = 0;
        in_TXFifoDataAck = 0;
        in_RXFifoDataValid = 0;
        in_busRXRead = 0;
        in_flush = 0;
        in_clearFlags = 0;
    endtask

    task automatic bus_push(input logic [31:0] d, input bit expect_ok);
        in_busTXWrite = 1;
        in_busTXData = d;
        if (expect_ok) tx_exp.push_back(d);
        cyc();
    endtask

    task automatic sm_push(input logic [31:0] d, input bit expect_ok);
        in_RXFifoDataValid = 1;
        in_dataRXFifo = d;
        if (expect_ok) rx_exp.push_back(d);
        cyc();
    endtask

    task automatic sm_ack();
        in_TXFifoDataAck = 1;
        cyc();
    endtask

    task automatic bus_read();
        in_busRXRead = 1;
        cyc();
    endtask

    function automatic logic [3:0] flags();
        return {out_TXOverflow, out_RXUnderflow, out_TXStall, out_RXStall};
    endfunction

    initial begin
        cyc();
        cyc();
        reset = 0;
        chk("rst_tx_empty", out_TXFifoEmpty, 1);
        chk("rst_rx_empty", out_RXFifoEmpty, 1);
        chk("rst_fulls", {out_TXFifoFull, out_RXFifoFull}, 0);
        chk("rst_levels", {out_TXLevel, out_RXLevel}, 0);
        chk("rst_data", out_dataTXFifo | out_busRXData, 0);
        chk("rst_flags", flags(), 0);

        for (int i = 0; i < 4; i++) bus_push(32'hA0 + i, 1);
        chk("tx_full", out_TXFifoFull, 1);
        chk("tx_lvl4", out_TXLevel, 4);
        chk("tx_head_a0", out_dataTXFifo, 32'hA0);
        bus_push(32'hA4, 0);
        chk("tx_ovf", out_TXOverflow, 1);
        chk("tx_lvl_ovf", out_TXLevel, 4);
        for (int i = 0; i < 4; i++) sm_ack();
        chk("tx_empty_after", out_TXFifoEmpty, 1);
        chk("tx_lvl0", out_TXLevel, 0);
        in_clearFlags = 1;
        cyc();
        chk("clr_flags1", flags(), 0);

        for (int i = 0; i < 4; i++) bus_push(32'h10 + i, 1);
        in_busTXWrite = 1;
        in_busTXData = 32'hB0;
        in_TXFifoDataAck = 1;
        tx_exp.push_back(32'hB0);
        cyc();
        chk("full_pushpop_lvl", out_TXLevel, 4);
        chk("full_pushpop_noovf", out_TXOverflow, 0);
        for (int i = 0; i < 4; i++) sm_ack();
        chk("tx_empty_b0", out_TXFifoEmpty, 1);

        in_busTXWrite = 1;
        in_busTXData = 32'hC0;
        in_TXFifoDataAck = 1;
        tx_exp.push_back(32'hC0);
        cyc();
        chk("empty_pushpop_stall", flags(), 4'b0010);
        chk("empty_pushpop_lvl", out_TXLevel, 1);
        chk("empty_pushpop_head", out_dataTXFifo, 32'hC0);
        bus_push(32'hD0, 1);
        chk("tx_lvl2", out_TXLevel, 2);

        in_joinTX = 1;
        cyc();
        tx_exp.delete();
        chk("jtx_flush_lvl", {out_TXLevel, out_RXLevel}, 0);
        chk("jtx_empty", out_TXFifoEmpty, 1);
        for (int i = 0; i < 8; i++) bus_push(32'hE0 + i, 1);
        chk("jtx_lvl8", out_TXLevel, 8);
        chk("jtx_full", out_TXFifoFull, 1);
        chk("jtx_rx_full_empty", {out_RXFifoFull, out_RXFifoEmpty}, 2'b11);
        chk("jtx_no_ovf", out_TXOverflow, 0);
        sm_push(32'h55, 0);
        chk("jtx_rxstall", out_RXStall, 1);
        chk("jtx_rxlvl", out_RXLevel, 0);
        for (int i = 0; i < 8; i++) sm_ack();
        chk("jtx_drained", out_TXFifoEmpty, 1);

        in_joinTX = 0;
        in_joinRX = 1;
        in_clearFlags = 1;
        cyc();
        chk("jrx_flags_clr", flags(), 0);
        chk("jrx_tx_full_empty", {out_TXFifoFull, out_TXFifoEmpty}, 2'b11);
        for (int i = 0; i < 8; i++) sm_push(32'h300 + i, 1);
        chk("jrx_lvl8", out_RXLevel, 8);
        chk("jrx_full", out_RXFifoFull, 1);
        bus_push(32'h77, 0);
        chk("jrx_txovf", out_TXOverflow, 1);
        chk("jrx_txlvl", out_TXLevel, 0);
        for (int i = 0; i < 8; i++) bus_read();
        chk("jrx_drained", out_RXFifoEmpty, 1);

        in_joinRX = 0;
        in_clearFlags = 1;
        cyc();
        sm_push(32'h11, 1);
        sm_push(32'h22, 1);
        chk("rx_head_11", out_busRXData, 32'h11);
        chk("rx_lvl2", out_RXLevel, 2);
        bus_read();
        bus_read();
        bus_read();
        chk("rx_underflow", flags(), 4'b0100);
        in_clearFlags = 1;
        cyc();
        chk("clr_flags2", flags(), 0);
        in_busRXRead = 1;
        in_clearFlags = 1;
        cyc();
        chk("set_beats_clear", out_RXUnderflow, 1);

        bus_push(32'hF0, 0);
        bus_push(32'hF1, 0);
        in_flush = 1;
        cyc();
        chk("flush_lvl", out_TXLevel, 0);
        chk("flush_empty", out_TXFifoEmpty, 1);

        bus_push(32'h1234, 0);
        bus_push(32'h5678, 0);
        sm_push(32'h9A, 0);
        sm_push(32'hBC, 0);
        chk("pre_rst_lvls", {out_TXLevel, out_RXLevel}, 8'h22);
        reset = 1;
        cyc();
        chk("rst2_levels", {out_TXLevel, out_RXLevel}, 0);
        chk("rst2_empties", {out_TXFifoEmpty, out_RXFifoEmpty}, 2'b11);
        chk("rst2_flags", flags(), 0);
        chk("rst2_data", out_dataTXFifo | out_busRXData, 0);
        reset = 0;
        cyc();

        chk("tx_sb_empty", tx_exp.size(), 0);
        chk("rx_sb_empty", rx_exp.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
